// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, nibble type and scan-state enum for the segment scanner
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  typedef logic [3:0] nibble_t;
  typedef enum logic {EMPTY, PENDING} scan_state_t;
  function automatic nibble_t nib(input logic [4*NUM_DIGITS-1:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/refresh_tick.sv
// refresh_tick: free-running 0..DIV-1 prescaler; tick marks the last count of each slot
module refresh_tick #(
  parameter int DIV = 50000,
  parameter int CW = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick,
  output logic [CW-1:0] count
);
  assign tick = count == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner with guard blanking, leading-zero
// suppression and a one-deep pending buffer swapped in only at frame wrap
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    load_ready,
  input  logic                    lz_en,
  output logic [3:0]              bin,
  output logic [3:0]              an_n,
  output logic [1:0]              digit_idx
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] G = CW'(GUARD);
  logic tick, wrap, blank_n;
  logic [CW-1:0] count, cnt_n;
  logic [1:0] idx_n;
  logic [4*NUM_DIGITS-1:0] pending, active, act_n;
  scan_state_t state;
  refresh_tick #(.DIV(REFRESH_DIV), .CW(CW)) u_tick (
    .clk(clk), .rst_n(rst_n), .tick(tick), .count(count)
  );
  assign load_ready = state == EMPTY;
  // outputs are registered from next-cycle values so they change on the same edge as digit_idx
  always_comb begin
    wrap = tick && digit_idx == 2'd3;
    cnt_n = tick ? '0 : count + 1'b1;
    idx_n = tick ? digit_idx + 2'd1 : digit_idx;
    act_n = wrap && state == PENDING ? pending : active;
    blank_n = lz_en && idx_n != 2'd0 && (act_n >> {idx_n, 2'b00}) == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= EMPTY;
      pending   <= '0;
      active    <= '0;
      digit_idx <= '0;
      bin       <= '0;
      an_n      <= 4'hF;
    end else begin
      digit_idx <= idx_n;
      active    <= act_n;
      bin       <= nib(act_n, idx_n);
      an_n      <= cnt_n < G || blank_n ? 4'hF : ~(4'b1 << idx_n);
      if (state == EMPTY && load) begin
        pending <= digits_in;
        state   <= PENDING;
      end else if (state == PENDING && wrap) state <= EMPTY;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: cycle-level reference model with a pending-value scoreboard queue
module tb_seg_scan_ctrl;
  logic clk = 0, rst_n = 0, load = 0, lz_en = 0;
  logic [15:0] digits_in = '0;
  logic load_ready;
  logic [3:0] bin, an_n;
  logic [1:0] digit_idx;
  int errors = 0, checks = 0;
  int m_cnt = 0, m_idx = 0;
  logic m_lz = 0;
  logic [15:0] m_active = '0;
  logic [15:0] pend_q[$];

  seg_scan_ctrl #(.REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .load_ready(load_ready),
    .lz_en(lz_en), .bin(bin), .an_n(an_n), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_bin();
    return m_active[m_idx*4 +: 4];
  endfunction

  function automatic logic [3:0] exp_an();
    logic blank = 0;
    if (m_lz && m_idx != 0) begin
      blank = 1;
      for (int k = m_idx; k < 4; k++) if (m_active[k*4 +: 4] != 4'h0) blank = 0;
    end
    if (m_cnt < 1 || blank) return 4'hF;
    return ~(4'b0001 << m_idx);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_active = '0; m_lz = 0;
    pend_q.delete();
  endtask

  // one clock: inputs held across the edge, model advances with the pre-edge inputs
  task automatic cyc(input logic ld, input logic [15:0] d);
    logic acc;
    load = ld;
    digits_in = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      acc = ld && pend_q.size() == 0;
      if (m_cnt == 3 && m_idx == 3 && pend_q.size() > 0) m_active = pend_q.pop_front();
      if (acc) pend_q.push_back(d);
      m_lz = lz_en;
      m_cnt = (m_cnt + 1) % 4;
      if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
    end
    #1;
    load = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'h0);
  endtask

  task automatic go_wrap();
    for (int i = 0; i < 20 && !(m_cnt == 3 && m_idx == 3); i++) cyc(0, 16'h0);
    chk("wrap_reached", 16'(m_cnt == 3 && m_idx == 3), 16'h1);
  endtask

  always @(negedge clk) begin
    chk("an_n", 16'(an_n), 16'(exp_an()));
    chk("bin", 16'(bin), 16'(exp_bin()));
    chk("digit_idx", 16'(digit_idx), 16'(m_idx));
    chk("load_ready", 16'(load_ready), 16'(pend_q.size() == 0));
  end

  initial begin
    model_reset();
    idle(3);
    chk("rst_an", 16'(an_n), 16'hF);
    chk("rst_bin", 16'(bin), 16'h0);
    chk("rst_ready", 16'(load_ready), 16'h1);
    rst_n = 1;
    cyc(0, 16'h0);
    chk("guard_off", 16'(an_n), 16'hE);
    idle(20);
    cyc(1, 16'h1234);
    chk("ready_low", 16'(load_ready), 16'h0);
    cyc(1, 16'hFFFF);
    go_wrap();
    cyc(0, 16'h0);
    chk("shown_d0", 16'(bin), 16'h4);
    chk("ready_back", 16'(load_ready), 16'h1);
    idle(16);
    lz_en = 1;
    cyc(1, 16'h0050);
    go_wrap();
    idle(32);
    lz_en = 0;
    idle(16);
    go_wrap();
    cyc(1, 16'hABCD);
    idle(15);
    chk("wrap_load_idx", 16'(digit_idx), 16'h3);
    chk("wrap_load_old", 16'(bin), 16'h0);
    cyc(0, 16'h0);
    chk("wrap_load_show", 16'(bin), 16'hD);
    idle(5);
    cyc(1, 16'h5555);
    idle(3);
    rst_n = 0;
    model_reset();
    #1;
    chk("midrst_an", 16'(an_n), 16'hF);
    chk("midrst_ready", 16'(load_ready), 16'h1);
    idle(2);
    rst_n = 1;
    idle(40);
    chk("lost_pending", 16'(bin), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
